// File: rtl/data_mem_be.sv
// rtl/data_mem_be.sv - byte-enable data memory with self-clearing init FSM
// DATAMEM_FWD_EN: a same-address read returns the byte-merged write word instead of the old word.
module data_mem_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ready,
  output logic              err
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                ready_q;
  logic                err_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_in;
  logic                rd_in;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   rd_data_d;

  assign wr_in = {1'b0, wr_addr} < DEPTH_L;
  assign rd_in = {1'b0, rd_addr} < DEPTH_L;

  always_comb begin
    old_word = '0;
    if (rd_in) old_word = mem_q[rd_addr];
  end

`ifdef DATAMEM_FWD_EN
  logic [DATA_W-1:0] merged_word;

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) merged_word[8*i +: 8] = wr_data[8*i +: 8];
    end
    rd_data_d = old_word;
    if (wr_en && wr_in && rd_in && (wr_addr == rd_addr)) rd_data_d = merged_word;
  end
`else
  always_comb begin
    rd_data_d = old_word;
  end
`endif

  // Storage has no reset; reset must leave contents untouched, only INIT clears them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_INIT) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en && wr_in) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else if (state_q == S_INIT) begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if (cnt_q == LAST_L) begin
        state_q <= S_RUN;
        ready_q <= 1'b1;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      rd_valid_q <= rd_en;
      err_q      <= (wr_en && !wr_in) || (rd_en && !rd_in);
      if (rd_en) rd_data_q <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ready    = ready_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_be.sv
// tb/tb_data_mem_be.sv - bench for data_mem_be at DEPTH 512 and DEPTH 500 driven in lockstep
module tb_data_mem_be;

`ifdef DATAMEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [8:0]  wr_addr, rd_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] dout [2];
  logic        dval [2];
  logic        drdy [2];
  logic        derr [2];

  int ncmp = 0;
  int nfail = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  data_mem_be #(.DATA_W(32), .ADDR_W(9), .DEPTH(512)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(dout[0]), .rd_valid(dval[0]), .ready(drdy[0]), .err(derr[0]));

  data_mem_be #(.DATA_W(32), .ADDR_W(9), .DEPTH(500)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(dout[1]), .rd_valid(dval[1]), .ready(drdy[1]), .err(derr[1]));

  function automatic int dep(input int k);
    return (k == 0) ? 512 : 500;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory array plus clear progress counted in cycles since reset release.
  logic [31:0] mmem [2][512];
  int          icnt [2];
  bit          mrdy [2];
  logic [31:0] e_rd [2];
  logic        e_v [2];
  logic        e_err [2];

  always @(posedge clk or negedge rst_n) begin : model
    int d;
    logic [31:0] old;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        icnt[k] = 0; mrdy[k] = 1'b0; e_rd[k] = '0; e_v[k] = 1'b0; e_err[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        d = dep(k);
        if (!mrdy[k]) begin
          mmem[k][icnt[k]] = '0;
          icnt[k]++;
          if (icnt[k] == d) mrdy[k] = 1'b1;
          e_v[k] = 1'b0; e_err[k] = 1'b0;
        end else begin
          old = (int'(rd_addr) < d) ? mmem[k][rd_addr] : 32'h0;
          e_v[k] = rd_en;
          e_err[k] = (wr_en && int'(wr_addr) >= d) || (rd_en && int'(rd_addr) >= d);
          if (rd_en) begin
            if (FWD && wr_en && wr_addr == rd_addr && int'(rd_addr) < d)
              e_rd[k] = merge(old, wr_data, wr_be);
            else
              e_rd[k] = old;
          end
          if (wr_en && int'(wr_addr) < d)
            mmem[k][wr_addr] = merge(mmem[k][wr_addr], wr_data, wr_be);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d rd_data", k), dout[k], e_rd[k]);
        chk($sformatf("m%0d rd_valid", k), 32'(dval[k]), 32'(e_v[k]));
        chk($sformatf("m%0d ready", k), 32'(drdy[k]), 32'(mrdy[k]));
        chk($sformatf("m%0d err", k), 32'(derr[k]), 32'(e_err[k]));
      end
    end
  end

  task automatic step(input logic we, input logic [8:0] wa, input logic [3:0] be,
                      input logic [31:0] wd, input logic re, input logic [8:0] ra);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 9'd0, 4'h0, 32'h0, 1'b0, 9'd0);
  endtask

  task automatic wait_ready(input int noise, output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int k = 1; k <= 700 && (c0 == 0 || c1 == 0); k++) begin
      if (k <= noise) step(1'b1, 9'($urandom), 4'hF, $urandom, 1'b1, 9'($urandom));
      else idle();
      if (drdy[0] && c0 == 0) c0 = k;
      if (drdy[1] && c1 == 0) c1 = k;
    end
  endtask

  task automatic check_reset_now(input string name);
    for (int k = 0; k < 2; k++) begin
      chk({name, " rd_data"}, dout[k], 32'h0);
      chk({name, " flags"}, {29'h0, dval[k], drdy[k], derr[k]}, 32'h0);
    end
  endtask

  initial begin
    int c0, c1, nz;
    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
    #1 chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_now("reset");
    rst_n = 1'b1;

    wait_ready(400, c0, c1);
    chk("ready cycles d512", 32'(c0), 32'd512);
    chk("ready cycles d500", 32'(c1), 32'd500);

    step(1'b0, 9'd0, 4'h0, 32'h0, 1'b1, 9'd5);
    chk("read5 d512", dout[0], 32'h0);
    chk("read5 valid", 32'(dval[0]), 32'd1);
    idle();
    chk("valid drops", 32'(dval[0]), 32'd0);

    step(1'b1, 9'd0, 4'b1111, 32'h3243F6A8, 1'b0, 9'd0);
    step(1'b1, 9'd0, 4'b0010, 32'h0000FF00, 1'b0, 9'd0);
    step(1'b0, 9'd0, 4'h0, 32'h0, 1'b1, 9'd0);
    chk("be merge d512", dout[0], 32'h3243FFA8);
    chk("be merge d500", dout[1], 32'h3243FFA8);
    idle();
    chk("hold rd_data", dout[0], 32'h3243FFA8);

    step(1'b1, 9'd7, 4'b1111, 32'h11223344, 1'b0, 9'd0);
    step(1'b1, 9'd7, 4'b0011, 32'hAABBCCDD, 1'b1, 9'd7);
    chk("collision read", dout[0], FWD ? 32'h1122CCDD : 32'h11223344);
    step(1'b0, 9'd0, 4'h0, 32'h0, 1'b1, 9'd7);
    chk("after collision", dout[1], 32'h1122CCDD);

    step(1'b1, 9'd500, 4'hF, 32'hFFFFFFFF, 1'b0, 9'd0);
    chk("oor write err d500", 32'(derr[1]), 32'd1);
    chk("inrange write err d512", 32'(derr[0]), 32'd0);
    step(1'b0, 9'd0, 4'h0, 32'h0, 1'b1, 9'd511);
    chk("oor read data", dout[1], 32'h0);
    chk("oor read valid/err", {30'h0, dval[1], derr[1]}, 32'd3);
    step(1'b0, 9'd0, 4'h0, 32'h0, 1'b1, 9'd500);
    chk("d512 word500", dout[0], 32'hFFFFFFFF);

    step(1'b1, 9'd10, 4'hF, 32'hDEADBEEF, 1'b0, 9'd0);
    step(1'b1, 9'd11, 4'b1001, 32'h01020304, 1'b1, 9'd10);
    chk("rw diff read", dout[0], 32'hDEADBEEF);
    step(1'b1, 9'd10, 4'b0000, 32'hFFFFFFFF, 1'b1, 9'd11);
    chk("b2b read", dout[1], 32'h01000004);
    chk("b2b valid", 32'(dval[1]), 32'd1);
    step(1'b0, 9'd0, 4'h0, 32'h0, 1'b1, 9'd10);
    chk("be0 unchanged", dout[0], 32'hDEADBEEF);
    idle();

    #2 rst_n = 1'b0;
    #1 check_reset_now("run reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(0, c0, c1);
    chk("rerun ready d512", 32'(c0), 32'd512);
    chk("rerun ready d500", 32'(c1), 32'd500);

    step(1'b1, 9'd3, 4'hF, 32'h55AA55AA, 1'b0, 9'd0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_now("pre-init reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) idle();
    #2 rst_n = 1'b0;
    #1 check_reset_now("init reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(0, c0, c1);
    chk("reinit ready d512", 32'(c0), 32'd512);
    chk("reinit ready d500", 32'(c1), 32'd500);

    nz = 0;
    for (int a = 0; a < 512; a++) begin
      step(1'b0, 9'd0, 4'h0, 32'h0, 1'b1, 9'(a));
      if (dout[0] !== 32'h0 || dout[1] !== 32'h0) nz++;
    end
    chk("all words zero", 32'(nz), 32'd0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
